// File: rtl/array_mult_bank.sv
// rtl/array_mult_bank.sv - LANES-wide pipelined signed Q-format multiplier bank with tag pass-through
// Optional saturation on overflow when ARRAY_MULT_SAT_EN is defined; otherwise results wrap.
module array_mult_bank #(
    parameter int WIDTH   = 36,
    parameter int FRAC    = 20,
    parameter int LANES   = 6,
    parameter int LATENCY = 3,
    parameter int TAG_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic [TAG_W-1:0]             in_tag,
    input  logic [LANES-1:0][WIDTH-1:0]  array_mult_dataa,
    input  logic [LANES-1:0][WIDTH-1:0]  array_mult_datab,
    output logic [LANES-1:0][WIDTH-1:0]  array_mult_result,
    output logic                         out_valid,
    output logic [TAG_W-1:0]             out_tag
);

    localparam int PW = 2 * WIDTH;

    generate
        if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
            $error("array_mult_bank: LATENCY must be in 1..8");
        end
    endgenerate

    // Bubbles carry zero data so an idle pipe never toggles the result bus.
    logic [LANES-1:0][PW-1:0] prod_comb;

    always_comb begin
        prod_comb = '0;
        for (int i = 0; i < LANES; i++) begin
            if (in_valid) begin
                prod_comb[i] = $signed({{WIDTH{array_mult_dataa[i][WIDTH-1]}}, array_mult_dataa[i]})
                             * $signed({{WIDTH{array_mult_datab[i][WIDTH-1]}}, array_mult_datab[i]});
            end
        end
    end

    logic                     final_valid;
    logic [TAG_W-1:0]         final_tag;
    logic [LANES-1:0][PW-1:0] final_prod;

    generate
        if (LATENCY == 1) begin : g_direct
            assign final_valid = in_valid;
            assign final_tag   = in_valid ? in_tag : '0;
            assign final_prod  = prod_comb;
        end else begin : g_pipe
            localparam int PD = LATENCY - 1;

            logic [PD-1:0]                      v_pipe;
            logic [PD-1:0][TAG_W-1:0]           t_pipe;
            logic [PD-1:0][LANES-1:0][PW-1:0]   p_pipe;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_pipe <= '0;
                    t_pipe <= '0;
                    p_pipe <= '0;
                end else if (en) begin
                    v_pipe[0] <= in_valid;
                    t_pipe[0] <= in_valid ? in_tag : '0;
                    p_pipe[0] <= prod_comb;
                    for (int s = 1; s < PD; s++) begin
                        v_pipe[s] <= v_pipe[s-1];
                        t_pipe[s] <= t_pipe[s-1];
                        p_pipe[s] <= p_pipe[s-1];
                    end
                end
            end

            assign final_valid = v_pipe[PD-1];
            assign final_tag   = t_pipe[PD-1];
            assign final_prod  = p_pipe[PD-1];
        end
    endgenerate

    // Taking bits [WIDTH+FRAC-1:FRAC] is the arithmetic shift by FRAC narrowed to WIDTH (floor).
    logic [LANES-1:0][WIDTH-1:0] narrowed;
    logic                        unused_prod;

    assign unused_prod = ^final_prod;

    always_comb begin
        narrowed = '0;
        for (int i = 0; i < LANES; i++) begin
            narrowed[i] = final_prod[i][WIDTH+FRAC-1:FRAC];
`ifdef ARRAY_MULT_SAT_EN
            // Bits above the result sign must all match the sign, otherwise clamp.
            if (!(&final_prod[i][PW-1:WIDTH+FRAC-1]) && (|final_prod[i][PW-1:WIDTH+FRAC-1])) begin
                narrowed[i] = final_prod[i][PW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                  : {1'b0, {(WIDTH-1){1'b1}}};
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            array_mult_result <= '0;
            out_valid         <= 1'b0;
            out_tag           <= '0;
        end else if (en) begin
            array_mult_result <= narrowed;
            out_valid         <= final_valid;
            out_tag           <= final_tag;
        end
    end

endmodule

// File: tb/tb_array_mult_bank.sv
// tb/tb_array_mult_bank.sv - directed table-driven bench for array_mult_bank (LATENCY=3, 6 lanes)
module tb_array_mult_bank;

    localparam int W = 36;
    localparam int L = 6;
    localparam int T = 8;
    localparam logic [W-1:0] ONE = 36'h0_0010_0000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic                 in_valid;
    logic [T-1:0]         in_tag;
    logic [L-1:0][W-1:0]  da;
    logic [L-1:0][W-1:0]  db;
    logic [L-1:0][W-1:0]  res;
    logic                 out_valid;
    logic [T-1:0]         out_tag;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    array_mult_bank dut (
        .clk               (clk),
        .rst               (rst),
        .en                (en),
        .in_valid          (in_valid),
        .in_tag            (in_tag),
        .array_mult_dataa  (da),
        .array_mult_datab  (db),
        .array_mult_result (res),
        .out_valid         (out_valid),
        .out_tag           (out_tag)
    );

    typedef struct {
        logic [L-1:0][W-1:0] a;
        logic [L-1:0][W-1:0] b;
        logic [L-1:0][W-1:0] e;
    } vec_t;

    vec_t vecs[3];

    logic       seq_v[13];
    logic [7:0] seq_t[13];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_tag   = '0;
        da       = '0;
        db       = '0;
    endtask

    task automatic chk_out(input string name, input logic v, input logic [7:0] t, input logic [W-1:0] r0);
        chk({name, "_valid"}, W'(out_valid), W'(v));
        chk({name, "_tag"},   W'(out_tag),   W'(t));
        chk({name, "_lane0"}, res[0],        r0);
    endtask

    task automatic set_lane(input int v, input int l, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] e);
        vecs[v].a[l] = a;
        vecs[v].b[l] = b;
        vecs[v].e[l] = e;
    endtask

    initial begin
        // vector 0: basic and sign/truncation cases
        set_lane(0, 0, 36'h0_0018_0000, 36'h0_0020_0000, 36'h0_0030_0000);
        set_lane(0, 1, 36'hF_FFF0_0000, 36'h0_0008_0000, 36'hF_FFF8_0000);
        set_lane(0, 2, 36'hF_FFFF_FFFF, 36'h0_0008_0000, 36'hF_FFFF_FFFF);
        set_lane(0, 3, 36'h0_0000_0000, 36'h1_2345_6789, 36'h0_0000_0000);
        set_lane(0, 4, 36'hF_FFF0_0000, 36'hF_FFF0_0000, 36'h0_0010_0000);
        set_lane(0, 5, 36'h0_0030_0000, 36'hF_FFE0_0000, 36'hF_FFA0_0000);
        // vector 1: tiny values, identity
        set_lane(1, 0, 36'h0_0000_0001, 36'h0_0000_0001, 36'h0_0000_0000);
        set_lane(1, 1, 36'h0_0008_0000, 36'h0_0008_0000, 36'h0_0004_0000);
        set_lane(1, 2, 36'hF_FFF8_0000, 36'hF_FFF8_0000, 36'h0_0004_0000);
        set_lane(1, 3, ONE,             36'h1_2345_6789, 36'h1_2345_6789);
        set_lane(1, 4, 36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 36'h0_0000_0000);
        set_lane(1, 5, 36'h0_0000_0001, ONE,             36'h0_0000_0001);
        // vector 2: overflow behaviour
`ifdef ARRAY_MULT_SAT_EN
        set_lane(2, 0, 36'h7_FFFF_FFFF, 36'h0_0020_0000, 36'h7_FFFF_FFFF);
        set_lane(2, 1, 36'h8_0000_0000, 36'h0_0020_0000, 36'h8_0000_0000);
        set_lane(2, 3, 36'h8_0000_0000, 36'h8_0000_0000, 36'h7_FFFF_FFFF);
`else
        set_lane(2, 0, 36'h7_FFFF_FFFF, 36'h0_0020_0000, 36'hF_FFFF_FFFE);
        set_lane(2, 1, 36'h8_0000_0000, 36'h0_0020_0000, 36'h0_0000_0000);
        set_lane(2, 3, 36'h8_0000_0000, 36'h8_0000_0000, 36'h0_0000_0000);
`endif
        set_lane(2, 2, 36'hF_FFF0_0000, 36'h7_FFFF_FFFF, 36'h8_0000_0001);
        set_lane(2, 4, 36'h8_0000_0000, ONE,             36'h8_0000_0000);
        set_lane(2, 5, 36'h0_0000_0000, 36'h7_FFFF_FFFF, 36'h0_0000_0000);

        // reset state
        rst = 1'b1;
        en  = 1'b1;
        idle();
        tick();
        tick();
        chk_out("reset", 1'b0, 8'h00, '0);
        rst = 1'b0;

        // table vectors: result exactly after the 3rd enabled edge
        for (int v = 0; v < 3; v++) begin
            da       = vecs[v].a;
            db       = vecs[v].b;
            in_valid = 1'b1;
            in_tag   = 8'h10 + 8'(v);
            tick();
            idle();
            tick();
            chk($sformatf("vec%0d_early_valid", v), W'(out_valid), W'(1'b0));
            tick();
            chk($sformatf("vec%0d_valid", v), W'(out_valid), W'(1'b1));
            chk($sformatf("vec%0d_tag", v),   W'(out_tag),   W'(8'h10 + 8'(v)));
            for (int l = 0; l < L; l++)
                chk($sformatf("vec%0d_lane%0d", v, l), res[l], vecs[v].e[l]);
            tick();
            chk($sformatf("vec%0d_not_sticky", v), W'(out_valid), W'(1'b0));
        end

        // streaming with a bubble and tag wrap FF -> 00
        for (int i = 0; i < 13; i++) begin
            seq_v[i] = (i != 4);
            seq_t[i] = (i < 4) ? 8'(i) : (i == 4) ? 8'h55 : (i < 11) ? 8'(i - 1) : (i == 11) ? 8'hFF : 8'h00;
        end
        for (int c = 0; c < 15; c++) begin
            idle();
            if (c < 13) begin
                in_valid = seq_v[c];
                in_tag   = seq_t[c];
                da[0]    = W'(seq_t[c]) << 20;
                db[0]    = ONE;
            end
            tick();
            if (c >= 2)
                chk_out($sformatf("stream%0d", c - 2), seq_v[c-2],
                        seq_v[c-2] ? seq_t[c-2] : 8'h00,
                        seq_v[c-2] ? (W'(seq_t[c-2]) << 20) : '0);
        end

        // stall: en low for 5 cycles right after issue
        idle();
        tick();
        tick();
        in_valid = 1'b1;
        in_tag   = 8'h2A;
        da[0]    = 36'h0_0018_0000;
        db[0]    = 36'h0_0020_0000;
        tick();
        en       = 1'b0;
        in_tag   = 8'h77;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_out($sformatf("stall%0d", k), 1'b0, 8'h00, '0);
        end
        idle();
        en = 1'b1;
        tick();
        chk_out("stall_resume1", 1'b0, 8'h00, '0);
        tick();
        chk_out("stall_result", 1'b1, 8'h2A, 36'h0_0030_0000);
        en = 1'b0;
        tick();
        tick();
        chk_out("stall_hold", 1'b1, 8'h2A, 36'h0_0030_0000);
        en = 1'b1;
        tick();
        chk_out("stall_no_dup", 1'b0, 8'h00, '0);
        tick();
        chk_out("stall_no_ghost", 1'b0, 8'h00, '0);

        // mid-flight reset, colliding with a third request
        for (int r = 0; r < 3; r++) begin
            in_valid = 1'b1;
            in_tag   = 8'(r + 1);
            da[0]    = ONE;
            db[0]    = ONE;
            rst      = (r == 2);
            tick();
        end
        rst = 1'b0;
        idle();
        chk_out("rst_mid", 1'b0, 8'h00, '0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_out($sformatf("rst_after%0d", k), 1'b0, 8'h00, '0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
